// File: rtl/led_matrix_capture_if.sv
// Framebuffer write port of the LED panel capture block: one bit-masked byte
// write per cycle while wr_en is high.
interface led_matrix_capture_if #(
    parameter int FB_ADDR_WIDTH = 12
);
    logic                     wr_en;
    logic [FB_ADDR_WIDTH-1:0] wr_addr;
    logic [7:0]               wr_data;
    logic [7:0]               wr_mask;

    modport master (output wr_en, wr_addr, wr_data, wr_mask);
    modport slave  (input  wr_en, wr_addr, wr_data, wr_mask);
endinterface

// File: rtl/led_matrix_capture.sv
// Receive side of a HUB-style LED panel: rebuilds shifted scan lines per bit-plane
// in ping-pong line buffers and drains each one into a bit-masked framebuffer.
module led_matrix_capture #(
    parameter int DISP_ADDR_WIDTH = 3,
    parameter int DISPLAY_WIDTH   = 416,
    parameter int FB_ADDR_WIDTH   = 12,
    parameter int PLANES          = 8,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       panel_clk_in,
    input  logic                       panel_data_in,
    input  logic                       panel_latch_in,
    input  logic [DISP_ADDR_WIDTH-1:0] panel_addr_in,
    led_matrix_capture_if.master       fb,
    output logic                       frame_done,
    output logic                       overrun,
    output logic                       len_error
);
    localparam int COL_W   = $clog2(DISPLAY_WIDTH + 1);
    localparam int PLANE_W = (PLANES > 1) ? $clog2(PLANES) : 1;
    localparam int SYNC_W  = DISP_ADDR_WIDTH + 3;

    typedef enum logic {IDLE, DRAIN} state_t;

    // Input synchronizer: every panel signal moves through the same stages so
    // data and address stay aligned with the clock and latch edges.
    logic [SYNC_W-1:0]          sync_q [SYNC_STAGES];
    logic [SYNC_W-1:0]          cur;
    logic                       prev_clk, prev_latch;
    logic                       s_clk, s_data, s_latch;
    logic [DISP_ADDR_WIDTH-1:0] s_addr;

    // NOTE: sequential state is only ever assigned with <=, so every flop samples
    // the pre-edge value of its neighbours regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            prev_clk   <= 1'b0;
            prev_latch <= 1'b0;
        end else begin
            sync_q[0] <= {panel_addr_in, panel_latch_in, panel_data_in, panel_clk_in};
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            prev_clk   <= s_clk;
            prev_latch <= s_latch;
        end
    end

    assign cur     = sync_q[SYNC_STAGES-1];
    assign s_clk   = cur[0];
    assign s_data  = cur[1];
    assign s_latch = cur[2];
    assign s_addr  = cur[SYNC_W-1:3];

    logic                       latch_rise, shift_en, other_busy, handoff;
    logic [COL_W-1:0]           col;
    logic [PLANE_W-1:0]         plane, plane_next;
    logic [DISP_ADDR_WIDTH-1:0] last_addr;
    logic                       fill_sel, drain_sel;
    logic [DISP_ADDR_WIDTH-1:0] drain_row;
    logic [PLANE_W-1:0]         drain_plane;
    logic [COL_W-1:0]           drain_len;
    logic [COL_W-1:0]           drain_i;
    logic                       drain_last;
    state_t                     state_q, state_d;

    assign latch_rise = s_latch && !prev_latch;
    // A clock edge coinciding with a latch edge sees s_latch high and is dropped.
    assign shift_en   = s_clk && !prev_clk && !s_latch && (col < COL_W'(DISPLAY_WIDTH));
    assign other_busy = (state_q == DRAIN) && (drain_sel != fill_sel);
    assign handoff    = latch_rise && !other_busy;
    assign drain_last = (drain_i == COL_W'(DISPLAY_WIDTH - 1));

    // NOTE: always_comb blocks assign a default first so no path can infer a latch.
    always_comb begin
        plane_next = '0;
        if (s_addr == last_addr)
            plane_next = (plane == PLANE_W'(PLANES - 1)) ? '0 : plane + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col         <= '0;
            plane       <= '0;
            last_addr   <= '0;
            fill_sel    <= 1'b0;
            drain_sel   <= 1'b0;
            drain_row   <= '0;
            drain_plane <= '0;
            drain_len   <= '0;
            len_error   <= 1'b0;
            overrun     <= 1'b0;
        end else if (latch_rise) begin
            col       <= '0;
            plane     <= plane_next;
            last_addr <= s_addr;
            if (col != COL_W'(DISPLAY_WIDTH)) len_error <= 1'b1;
            if (other_busy) begin
                overrun <= 1'b1;
            end else begin
                fill_sel    <= ~fill_sel;
                drain_sel   <= fill_sel;
                drain_row   <= s_addr;
                drain_plane <= plane_next;
                drain_len   <= col;
            end
        end else if (shift_en) begin
            col <= col + 1'b1;
        end
    end

    // NOTE: line buffers are storage, not control; they carry no reset because
    // bits beyond the committed length are masked off during drain.
    logic [DISPLAY_WIDTH-1:0] line_buf [2];

    always_ff @(posedge clk) begin
        if (shift_en) line_buf[fill_sel][col] <= s_data;
    end

    // Drain FSM: state register, next-state logic, output logic.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (handoff)    state_d = DRAIN;
            DRAIN:   if (drain_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                          drain_i <= '0;
        else if (handoff)                      drain_i <= '0;
        else if (state_q == DRAIN && !drain_last) drain_i <= drain_i + 1'b1;
    end

    logic                     wr_en_d, drain_bit, frame_last_d, frame_last_q;
    logic [FB_ADDR_WIDTH-1:0] wr_addr_d;
    logic [7:0]               wr_data_d, wr_mask_d;

    always_comb begin
        wr_en_d      = (state_q == DRAIN);
        drain_bit    = (drain_i < drain_len) && line_buf[drain_sel][drain_i];
        wr_addr_d    = FB_ADDR_WIDTH'(32'(drain_row) * 32'(DISPLAY_WIDTH) + 32'(drain_i));
        wr_data_d    = {8{drain_bit}};
        wr_mask_d    = 8'(1) << drain_plane;
        frame_last_d = wr_en_d && drain_last &&
                       (drain_row == {DISP_ADDR_WIDTH{1'b1}}) &&
                       (drain_plane == PLANE_W'(PLANES - 1));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fb.wr_en     <= 1'b0;
            fb.wr_addr   <= '0;
            fb.wr_data   <= '0;
            fb.wr_mask   <= '0;
            frame_last_q <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            fb.wr_en     <= wr_en_d;
            fb.wr_addr   <= wr_addr_d;
            fb.wr_data   <= wr_data_d;
            fb.wr_mask   <= wr_mask_d;
            frame_last_q <= frame_last_d;
            frame_done   <= frame_last_q;
        end
    end
endmodule

// File: tb/tb_led_matrix_capture.sv
// Scoreboard bench for led_matrix_capture: stimulus pushes expected framebuffer
// writes into a queue; a negedge monitor pops and compares every write.
`timescale 1ns/1ps
module tb_led_matrix_capture;
    localparam int W = 416;

    typedef struct packed {
        logic [11:0] addr;
        logic [7:0]  data;
        logic [7:0]  mask;
    } wr_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       panel_clk = 1'b0;
    logic       panel_data = 1'b0;
    logic       panel_latch = 1'b0;
    logic [2:0] panel_addr = '0;
    logic       frame_done, overrun, len_error;

    int  errors = 0;
    int  checks = 0;
    int  wr_cnt = 0;
    int  fd_cnt = 0;
    wr_t exp_q[$];

    logic        prev_wr_en = 1'b0;
    logic [11:0] prev_addr = '0;
    logic [7:0]  prev_mask = '0;

    led_matrix_capture_if #(.FB_ADDR_WIDTH(12)) bus ();

    led_matrix_capture #(
        .DISP_ADDR_WIDTH(3), .DISPLAY_WIDTH(W), .FB_ADDR_WIDTH(12),
        .PLANES(8), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .panel_clk_in(panel_clk), .panel_data_in(panel_data),
        .panel_latch_in(panel_latch), .panel_addr_in(panel_addr),
        .fb(bus.master),
        .frame_done(frame_done), .overrun(overrun), .len_error(len_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expected write per observed write.
    always @(negedge clk) begin
        if (reset_n) begin
            if (frame_done) begin
                fd_cnt++;
                check("frame_done_after_last_write", {11'd0, prev_wr_en, prev_addr, prev_mask},
                      {11'd0, 1'b1, 12'd3327, 8'h80});
            end
            if (bus.wr_en) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr=%0d data=0x%0h mask=0x%0h, expected none",
                             bus.wr_addr, bus.wr_data, bus.wr_mask);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("write", {bus.wr_addr, bus.wr_data, bus.wr_mask}, {e.addr, e.data, e.mask});
                end
            end
            prev_wr_en = bus.wr_en;
            prev_addr  = bus.wr_addr;
            prev_mask  = bus.wr_mask;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    function automatic logic pat_bit(input int i, input int mode);
        return (mode == 1) ? 1'b1 : (i % 2 == 0);
    endfunction

    task automatic push_row(input int row, input int plane, input int nbits, input int mode);
        wr_t e;
        for (int i = 0; i < W; i++) begin
            e.addr = 12'(row * W + i);
            e.data = ((i < nbits) && pat_bit(i, mode)) ? 8'hFF : 8'h00;
            e.mask = 8'(1) << plane;
            exp_q.push_back(e);
        end
    endtask

    // mode 0: alternating starting with 1 at column 0; mode 1: all ones
    task automatic shift_bits(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            panel_data = pat_bit(i, mode);
            tick(2);
            panel_clk = 1'b1;
            tick(2);
            panel_clk = 1'b0;
        end
    endtask

    task automatic latch_row(input int row, input bit commit, input int plane,
                             input int nbits, input int mode);
        panel_addr = 3'(row);
        tick(2);
        if (commit) push_row(row, plane, nbits, mode);
        panel_latch = 1'b1;
        tick(3);
        panel_latch = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            tick(1);
            n++;
        end
        check({name, "_drained"}, exp_q.size(), 0);
        tick(4);
    endtask

    initial begin
        int start;
        int n;

        tick(3);
        check("reset_wr_en", bus.wr_en, 0);
        check("reset_frame_done", frame_done, 0);
        check("reset_overrun", overrun, 0);
        check("reset_len_error", len_error, 0);
        reset_n = 1'b1;
        tick(3);

        // Alternating row on addr 3: addrs 1248..1663, plane 0
        shift_bits(W, 0);
        latch_row(3, 1, 0, W, 0);
        wait_drain("alt_row");
        check("alt_row_len_error", len_error, 0);
        check("alt_row_overrun", overrun, 0);

        // Nine latches on addr 5: masks 0x01..0x80 then wrap to 0x01
        for (int k = 0; k < 9; k++) begin
            shift_bits(W, 1);
            latch_row(5, 1, k % 8, W, 1);
        end
        wait_drain("plane_seq");
        check("plane_seq_overrun", overrun, 0);
        check("plane_seq_len_error", len_error, 0);

        // Short row: 400 bits, columns 400..415 written as 0
        shift_bits(400, 1);
        latch_row(2, 1, 0, 400, 1);
        wait_drain("short_row");
        check("short_row_len_error", len_error, 1);

        // Full frame: 8 rows x 8 planes of 4-bit rows
        for (int r = 0; r < 8; r++) begin
            for (int p = 0; p < 8; p++) begin
                shift_bits(4, 1);
                latch_row(r, 1, p, 4, 1);
                wait_drain("frame_row");
            end
        end
        tick(4);
        check("frame_done_count", fd_cnt, 1);

        // Overrun: second latch 10 cycles later while first row drains
        shift_bits(4, 1);
        latch_row(1, 1, 0, 4, 1);
        tick(5);
        latch_row(1, 0, 0, 0, 1);
        tick(4);
        check("overrun_set", overrun, 1);
        wait_drain("overrun_row");
        check("overrun_sticky", overrun, 1);

        // Reset mid-drain
        shift_bits(W, 0);
        latch_row(4, 1, 0, W, 0);
        start = wr_cnt;
        n = 0;
        while (wr_cnt - start < 20 && n < 200) begin
            tick(1);
            n++;
        end
        check("mid_drain_started", 32'(wr_cnt - start >= 20), 1);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_reset_wr_en", bus.wr_en, 0);
        check("mid_reset_overrun", overrun, 0);
        check("mid_reset_len_error", len_error, 0);
        exp_q.delete();
        tick(3);
        reset_n = 1'b1;
        tick(3);

        // Clean capture after reset: addr 6 is a new address -> plane 0
        start = wr_cnt;
        shift_bits(W, 1);
        latch_row(6, 1, 0, W, 1);
        wait_drain("post_reset_row");
        check("post_reset_write_count", wr_cnt - start, W);
        check("post_reset_len_error", len_error, 0);
        check("post_reset_overrun", overrun, 0);
        check("post_reset_frame_done_count", fd_cnt, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
